// File: rtl/tdm_demux_1_to_8.sv
// tdm_demux_1_to_8
// Receiving end of the 8-to-1 word multiplexer link. Slot words arrive one
// per valid cycle in selector order 0..7. They are collected in shadow
// registers, and a complete frame is published on Data_0..Data_7 in one
// coherent update.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   Serial_Data  incoming slot word (N_BITS)
//   Data_Valid   Serial_Data is valid this cycle
//   Frame_Start  marks the current valid word as slot 0
//   Data_0..7    last completed frame, slot k on Data_k (registered)
//   Frame_Ready  one-cycle pulse when a new frame is published
//   Frame_Error  one-cycle pulse when a partial frame is aborted by Frame_Start
//   Slot_Out     index of the next expected slot (0 while idle)
//   Busy         high while a frame is partially received
module tdm_demux_1_to_8 #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] Serial_Data,
  input  logic              Data_Valid,
  input  logic              Frame_Start,
  output logic [N_BITS-1:0] Data_0,
  output logic [N_BITS-1:0] Data_1,
  output logic [N_BITS-1:0] Data_2,
  output logic [N_BITS-1:0] Data_3,
  output logic [N_BITS-1:0] Data_4,
  output logic [N_BITS-1:0] Data_5,
  output logic [N_BITS-1:0] Data_6,
  output logic [N_BITS-1:0] Data_7,
  output logic              Frame_Ready,
  output logic              Frame_Error,
  output logic [2:0]        Slot_Out,
  output logic              Busy
);

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [N_BITS-1:0] shadow_q [8];
  logic [N_BITS-1:0] shadow_d [8];
  logic [N_BITS-1:0] data_q   [8];
  logic [N_BITS-1:0] data_d   [8];
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      data_q   <= '{default: '0};
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Words arriving without Frame_Start while idle are simply dropped.
        if (Data_Valid && Frame_Start) begin
          shadow_d[0] = Serial_Data;
          cnt_d       = 3'd1;
          state_d     = RECEIVE;
        end
      end

      RECEIVE: begin
        if (Data_Valid) begin
          if (Frame_Start) begin
            // Early restart: the partial frame is abandoned and this word
            // becomes slot 0. Stale shadows are overwritten before any publish.
            error_d     = 1'b1;
            shadow_d[0] = Serial_Data;
            cnt_d       = 3'd1;
          end else begin
            shadow_d[cnt_q] = Serial_Data;
            if (cnt_q == 3'd7) begin
              // Slot 7 bypasses the shadow so the frame publishes on this edge.
              for (int unsigned i = 0; i < 7; i++) begin
                data_d[3'(i)] = shadow_q[3'(i)];
              end
              data_d[7] = Serial_Data;
              ready_d   = 1'b1;
              cnt_d     = '0;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Data_0      = data_q[0];
  assign Data_1      = data_q[1];
  assign Data_2      = data_q[2];
  assign Data_3      = data_q[3];
  assign Data_4      = data_q[4];
  assign Data_5      = data_q[5];
  assign Data_6      = data_q[6];
  assign Data_7      = data_q[7];
  assign Frame_Ready = ready_q;
  assign Frame_Error = error_q;
  assign Slot_Out    = cnt_q;
  assign Busy        = (state_q == RECEIVE);

endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
module tb_tdm_demux_1_to_8;

  logic       clk;
  logic       reset;
  logic [7:0] Serial_Data;
  logic       Data_Valid;
  logic       Frame_Start;
  logic [7:0] dout [8];
  logic       Frame_Ready;
  logic       Frame_Error;
  logic [2:0] Slot_Out;
  logic       Busy;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the frame in progress is a queue of received words.
  logic [7:0] m_part [$];
  logic [7:0] m_out  [8];
  logic       m_ready;
  logic       m_error;

  int ready_count;
  int error_count;
  int cyc;
  int ready_cyc [$];

  tdm_demux_1_to_8 #(.N_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .Serial_Data (Serial_Data),
    .Data_Valid  (Data_Valid),
    .Frame_Start (Frame_Start),
    .Data_0      (dout[0]),
    .Data_1      (dout[1]),
    .Data_2      (dout[2]),
    .Data_3      (dout[3]),
    .Data_4      (dout[4]),
    .Data_5      (dout[5]),
    .Data_6      (dout[6]),
    .Data_7      (dout[7]),
    .Frame_Ready (Frame_Ready),
    .Frame_Error (Frame_Error),
    .Slot_Out    (Slot_Out),
    .Busy        (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input logic rst_n, input logic v, input logic fs, input logic [7:0] d);
    m_ready = 1'b0;
    m_error = 1'b0;
    if (!rst_n) begin
      m_part.delete();
      for (int i = 0; i < 8; i++) m_out[i] = 8'h00;
    end else if (v) begin
      if (fs) begin
        if (m_part.size() != 0) m_error = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end else if (m_part.size() != 0) begin
        m_part.push_back(d);
        if (m_part.size() == 8) begin
          for (int i = 0; i < 8; i++) m_out[i] = m_part[i];
          m_ready = 1'b1;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) check($sformatf("data_%0d", i), dout[i], m_out[i]);
    check("frame_ready", 8'(Frame_Ready), 8'(m_ready));
    check("frame_error", 8'(Frame_Error), 8'(m_error));
    check("slot_out",    8'(Slot_Out),    8'(m_part.size()));
    check("busy",        8'(Busy),        8'(m_part.size() != 0));
    check("ready_error_exclusive", 8'(Frame_Ready & Frame_Error), 8'h00);
  endtask

  // One clock: drive inputs, let the edge sample them, compare 1 time unit later.
  task automatic step(input logic rst_n, input logic v, input logic fs, input logic [7:0] d);
    reset       = rst_n;
    Data_Valid  = v;
    Frame_Start = fs;
    Serial_Data = d;
    @(posedge clk);
    cyc++;
    model_update(rst_n, v, fs, d);
    #1;
    if (Frame_Ready === 1'b1) begin
      ready_count++;
      ready_cyc.push_back(cyc);
    end
    if (Frame_Error === 1'b1) error_count++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] w [8], input int gap2, input int gap5);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, (k == 0), w[k]);
      if (k == 2) idle(gap2);
      if (k == 5) idle(gap5);
    end
  endtask

  logic [7:0] sf   [8];
  logic [7:0] fb   [8];
  logic [7:0] slot_seq [$];

  initial begin
    cyc         = 0;
    ready_count = 0;
    error_count = 0;
    sf = '{8'hEB, 8'd125, 8'hAA, 8'd3, 8'hFF, 8'd12, 8'd80, 8'd30};
    reset = 1'b0; Data_Valid = 1'b0; Frame_Start = 1'b0; Serial_Data = '0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    check("reset_busy", 8'(Busy), 8'h00);
    check("reset_slot", 8'(Slot_Out), 8'h00);
    idle(1);

    // Single frame: watch slot sequence and the published values
    slot_seq.delete();
    ready_count = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, (k == 0), sf[k]);
      slot_seq.push_back(8'(Slot_Out));
    end
    for (int k = 0; k < 8; k++) check($sformatf("sf_slot_%0d", k), slot_seq[k], 8'((k + 1) % 8));
    check("sf_d0", dout[0], 8'hEB); check("sf_d1", dout[1], 8'h7D);
    check("sf_d2", dout[2], 8'hAA); check("sf_d3", dout[3], 8'h03);
    check("sf_d4", dout[4], 8'hFF); check("sf_d5", dout[5], 8'h0C);
    check("sf_d6", dout[6], 8'h50); check("sf_d7", dout[7], 8'h1E);
    idle(3);
    check("sf_ready_pulses", 8'(ready_count), 8'd1);

    // Gapped frame: reset outputs first so the republish is visible
    step(1'b0, 1'b0, 1'b0, 8'h00);
    ready_count = 0;
    send_frame(sf, 3, 5);
    for (int k = 0; k < 8; k++) check($sformatf("gap_d%0d", k), dout[k], sf[k]);
    check("gap_ready_pulses", 8'(ready_count), 8'd1);

    // Early restart
    error_count = 0;
    ready_count = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, (k == 0), 8'($urandom));
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, (k == 0), 8'(8'h11 + k));
      if (k < 7) check($sformatf("er_hold_d%0d", k), dout[k], sf[k]);
    end
    for (int k = 0; k < 8; k++) check($sformatf("er_d%0d", k), dout[k], 8'(8'h11 + k));
    check("er_error_pulses", 8'(error_count), 8'd1);
    check("er_ready_pulses", 8'(ready_count), 8'd1);

    // Frame_Start at slot position 7 aborts without publishing
    error_count = 0;
    ready_count = 0;
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, (k == 0), 8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    check("s7_error_pulses", 8'(error_count), 8'd1);
    check("s7_ready_pulses", 8'(ready_count), 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Idle filtering, then reset mid-frame
    error_count = 0;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    check("idle_error_pulses", 8'(error_count), 8'd0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, (k == 0), 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h77);
    check("mid_reset_busy", 8'(Busy), 8'h00);
    check("mid_reset_error_pulses", 8'(error_count), 8'd0);
    send_frame(sf, 0, 0);
    for (int k = 0; k < 8; k++) check($sformatf("post_reset_d%0d", k), dout[k], sf[k]);

    // Back-to-back frames
    ready_cyc.delete();
    for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
    send_frame(sf, 0, 0);
    send_frame(fb, 0, 0);
    check("b2b_ready_pulses", 8'(ready_cyc.size()), 8'd2);
    if (ready_cyc.size() == 2) check("b2b_spacing", 8'(ready_cyc[1] - ready_cyc[0]), 8'd8);
    for (int k = 0; k < 8; k++) check($sformatf("b2b_d%0d", k), dout[k], fb[k]);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
